// File: rtl/serial_loader_pkg.sv
// Shared definitions for the host serial loader: command/reply codes, FSM encodings, helpers.
package serial_loader_pkg;

    localparam logic [7:0] CMD_LOAD    = 8'h4C;  // 'L'
    localparam logic [7:0] CMD_DUMP    = 8'h44;  // 'D'
    localparam logic [7:0] CMD_EXEC    = 8'h58;  // 'X'
    localparam logic [7:0] RPL_HALT    = 8'h48;  // 'H'
    localparam logic [7:0] RPL_BADCMD  = 8'h3F;  // '?'
    localparam logic [7:0] RPL_TIMEOUT = 8'h21;  // '!'

    typedef enum logic [3:0] {
        S_IDLE,
        S_A_HI,
        S_A_LO,
        S_LEN,
        S_LDATA,
        S_DRD,
        S_DWAIT,
        S_DTX,
        S_GO,
        S_RUN,
        S_TX,
        S_TXGAP
    } state_t;

    typedef enum logic [1:0] {
        T_IDLE,
        T_WAIT,
        T_SEND,
        T_GAP
    } tx_state_t;

    // A length byte of zero stands for a full 256-byte block.
    function automatic logic [8:0] len_of(input logic [7:0] n);
        return (n == 8'd0) ? 9'd256 : {1'b0, n};
    endfunction

endpackage

// File: rtl/serial_loader_tx_sender.sv
// One-byte UART transmit handshake: waits for the UART to go idle, pulses transmit, then holds one gap cycle.
module serial_loader_tx_sender
    import serial_loader_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic [7:0] req_byte,
    input  logic       is_transmitting,
    output logic       transmit,
    output logic [7:0] tx_byte,
    output logic       done
);

    tx_state_t state_q, state_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= T_IDLE;
            tx_byte <= 8'd0;
        end else begin
            state_q <= state_d;
            if (req && state_q == T_IDLE)
                tx_byte <= req_byte;
        end
    end

    // The gap cycle gives the UART time to raise its busy flag before the next request.
    always_comb begin
        state_d = state_q;
        case (state_q)
            T_IDLE: if (req) state_d = T_WAIT;
            T_WAIT: if (!is_transmitting) state_d = T_SEND;
            T_SEND: state_d = T_GAP;
            T_GAP:  state_d = T_IDLE;
            default: state_d = T_IDLE;
        endcase
    end

    assign transmit = (state_q == T_SEND);
    assign done     = (state_q == T_GAP);

endmodule

// File: rtl/serial_loader.sv
// Host monitor: parses UART commands to load/dump program RAM and to launch the cpu, replying over tx.
module serial_loader
    import serial_loader_pkg::*;
#(
    parameter int addr_width     = 9,
    parameter int TIMEOUT_CYCLES = 1200000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  received,
    input  logic [7:0]            rx_byte,
    input  logic                  is_transmitting,
    output logic                  transmit,
    output logic [7:0]            tx_byte,
    output logic [addr_width-1:0] raddr,
    input  logic [7:0]            dread,
    output logic [addr_width-1:0] waddr,
    output logic [7:0]            dwrite,
    output logic                  write_en,
    output logic [addr_width-1:0] startaddr,
    output logic                  cpu_go,
    output logic                  cpu_active,
    input  logic                  cpu_halted
);

    localparam int TCW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TCW-1:0] T_LIMIT = TCW'(TIMEOUT_CYCLES - 1);

    state_t                state_q, state_d, ret_q, ret_d;
    logic [7:0]            cmd_q, cmd_d;
    logic [7:0]            a_hi_q, a_hi_d;
    logic [addr_width-1:0] addr_q, addr_d;
    logic [8:0]            len_q, len_d;
    logic [7:0]            sum_q, sum_d;
    logic [TCW-1:0]        tcnt_q, tcnt_d;
    logic                  wcnt_q, wcnt_d;
    logic [7:0]            tx_data_q, tx_data_d;
    logic                  write_en_d, cpu_active_d;
    logic [addr_width-1:0] waddr_d, raddr_d, startaddr_d;
    logic [7:0]            dwrite_d;
    logic                  timed;
    logic                  tx_req, tx_done;

    serial_loader_tx_sender u_tx (
        .clk             (clk),
        .rst             (rst),
        .req             (tx_req),
        .req_byte        (tx_data_q),
        .is_transmitting (is_transmitting),
        .transmit        (transmit),
        .tx_byte         (tx_byte),
        .done            (tx_done)
    );

    assign tx_req = (state_q == S_TX);
    assign cpu_go = (state_q == S_GO);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            ret_q      <= S_IDLE;
            cmd_q      <= 8'd0;
            a_hi_q     <= 8'd0;
            addr_q     <= '0;
            len_q      <= 9'd0;
            sum_q      <= 8'd0;
            tcnt_q     <= '0;
            wcnt_q     <= 1'b0;
            tx_data_q  <= 8'd0;
            write_en   <= 1'b0;
            waddr      <= '0;
            dwrite     <= 8'd0;
            raddr      <= '0;
            startaddr  <= '0;
            cpu_active <= 1'b0;
        end else begin
            state_q    <= state_d;
            ret_q      <= ret_d;
            cmd_q      <= cmd_d;
            a_hi_q     <= a_hi_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            sum_q      <= sum_d;
            tcnt_q     <= tcnt_d;
            wcnt_q     <= wcnt_d;
            tx_data_q  <= tx_data_d;
            write_en   <= write_en_d;
            waddr      <= waddr_d;
            dwrite     <= dwrite_d;
            raddr      <= raddr_d;
            startaddr  <= startaddr_d;
            cpu_active <= cpu_active_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        ret_d        = ret_q;
        cmd_d        = cmd_q;
        a_hi_d       = a_hi_q;
        addr_d       = addr_q;
        len_d        = len_q;
        sum_d        = sum_q;
        wcnt_d       = wcnt_q;
        tx_data_d    = tx_data_q;
        write_en_d   = 1'b0;
        waddr_d      = waddr;
        dwrite_d     = dwrite;
        raddr_d      = raddr;
        startaddr_d  = startaddr;
        cpu_active_d = cpu_active;

        // Only the byte-gathering states are subject to the inter-byte timeout.
        timed  = (state_q inside {S_A_HI, S_A_LO, S_LEN, S_LDATA});
        tcnt_d = (received || !timed) ? '0 : tcnt_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                if (received) begin
                    cmd_d = rx_byte;
                    if (rx_byte == CMD_LOAD || rx_byte == CMD_DUMP || rx_byte == CMD_EXEC) begin
                        state_d = S_A_HI;
                    end else begin
                        tx_data_d = RPL_BADCMD;
                        ret_d     = S_IDLE;
                        state_d   = S_TX;
                    end
                end
            end
            S_A_HI: begin
                if (received) begin
                    a_hi_d  = rx_byte;
                    state_d = S_A_LO;
                end
            end
            S_A_LO: begin
                if (received) begin
                    addr_d = addr_width'({a_hi_q, rx_byte});
                    if (cmd_q == CMD_EXEC) begin
                        startaddr_d  = addr_width'({a_hi_q, rx_byte});
                        cpu_active_d = 1'b1;
                        state_d      = S_GO;
                    end else begin
                        state_d = S_LEN;
                    end
                end
            end
            S_LEN: begin
                if (received) begin
                    len_d   = len_of(rx_byte);
                    sum_d   = 8'd0;
                    state_d = (cmd_q == CMD_LOAD) ? S_LDATA : S_DRD;
                end
            end
            S_LDATA: begin
                if (received) begin
                    write_en_d = 1'b1;
                    waddr_d    = addr_q;
                    dwrite_d   = rx_byte;
                    sum_d      = sum_q + rx_byte;
                    addr_d     = addr_q + 1'b1;
                    len_d      = len_q - 1'b1;
                    if (len_q == 9'd1) begin
                        tx_data_d = sum_q + rx_byte;
                        ret_d     = S_IDLE;
                        state_d   = S_TX;
                    end
                end
            end
            S_DRD: begin
                raddr_d = addr_q;
                wcnt_d  = 1'b0;
                state_d = S_DWAIT;
            end
            // RAM read data arrives two clocks after raddr is registered.
            S_DWAIT: begin
                wcnt_d = 1'b1;
                if (wcnt_q) state_d = S_DTX;
            end
            S_DTX: begin
                tx_data_d = dread;
                addr_d    = addr_q + 1'b1;
                len_d     = len_q - 1'b1;
                ret_d     = (len_q == 9'd1) ? S_IDLE : S_DRD;
                state_d   = S_TX;
            end
            S_GO: state_d = S_RUN;
            S_RUN: begin
                if (cpu_halted) begin
                    cpu_active_d = 1'b0;
                    tx_data_d    = RPL_HALT;
                    ret_d        = S_IDLE;
                    state_d      = S_TX;
                end
            end
            S_TX:    if (transmit) state_d = S_TXGAP;
            S_TXGAP: if (tx_done) state_d = ret_q;
            default: state_d = S_IDLE;
        endcase

        if (timed && !received && tcnt_q == T_LIMIT) begin
            tx_data_d = RPL_TIMEOUT;
            ret_d     = S_IDLE;
            state_d   = S_TX;
        end
    end

endmodule

// File: tb/tb_serial_loader.sv
// Scoreboard bench for serial_loader: directed host commands, RAM and UART models, decoupled monitor.
module tb_serial_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       received;
    logic [7:0] rx_byte;
    logic       is_transmitting;
    logic       transmit;
    logic [7:0] tx_byte;
    logic [8:0] raddr, waddr, startaddr;
    logic [7:0] dread, dwrite;
    logic       write_en, cpu_go, cpu_active, cpu_halted;

    int tests = 0;
    int fails = 0;

    logic [16:0] exp_wr[$];
    logic [7:0]  exp_tx[$];
    logic [8:0]  exp_go[$];

    always #5 clk = ~clk;

    serial_loader #(.addr_width(9), .TIMEOUT_CYCLES(100)) dut (
        .clk             (clk),
        .rst             (rst),
        .received        (received),
        .rx_byte         (rx_byte),
        .is_transmitting (is_transmitting),
        .transmit        (transmit),
        .tx_byte         (tx_byte),
        .raddr           (raddr),
        .dread           (dread),
        .waddr           (waddr),
        .dwrite          (dwrite),
        .write_en        (write_en),
        .startaddr       (startaddr),
        .cpu_go          (cpu_go),
        .cpu_active      (cpu_active),
        .cpu_halted      (cpu_halted)
    );

    // RAM with two-clock read latency, UART busy for a few clocks after each transmit
    logic [7:0] mem [0:511];
    logic [7:0] rd_p1;
    int         busy_cnt = 0;

    always @(posedge clk) begin
        if (write_en) mem[waddr] <= dwrite;
        rd_p1 <= mem[raddr];
        dread <= rd_p1;
        if (transmit) busy_cnt <= 6;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end
    assign is_transmitting = (busy_cnt != 0);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (write_en || transmit)
                check("wr_tx_exclusive", {31'd0, write_en & transmit}, 32'd0);
            if (write_en) begin
                if (exp_wr.size() == 0) check("unexpected_write", {15'd0, waddr, dwrite}, 32'hFFFFFFFF);
                else check("write", {15'd0, waddr, dwrite}, {15'd0, exp_wr.pop_front()});
            end
            if (transmit) begin
                check("tx_while_busy", {31'd0, is_transmitting}, 32'd0);
                if (exp_tx.size() == 0) check("unexpected_tx", {24'd0, tx_byte}, 32'hFFFFFFFF);
                else check("tx_byte", {24'd0, tx_byte}, {24'd0, exp_tx.pop_front()});
            end
            if (cpu_go) begin
                check("go_active", {31'd0, cpu_active}, 32'd1);
                if (exp_go.size() == 0) check("unexpected_go", {23'd0, startaddr}, 32'hFFFFFFFF);
                else check("startaddr", {23'd0, startaddr}, {23'd0, exp_go.pop_front()});
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_byte  = b;
        received = 1'b1;
        @(negedge clk);
        received = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic drain(input int maxc);
        int n = 0;
        while ((exp_tx.size() + exp_wr.size() + exp_go.size()) != 0 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", exp_tx.size() + exp_wr.size() + exp_go.size(), 32'd0);
        exp_tx.delete();
        exp_wr.delete();
        exp_go.delete();
    endtask

    task automatic check_reset_outputs();
        check("rst_transmit", {31'd0, transmit}, 32'd0);
        check("rst_write_en", {31'd0, write_en}, 32'd0);
        check("rst_cpu_go", {31'd0, cpu_go}, 32'd0);
        check("rst_cpu_active", {31'd0, cpu_active}, 32'd0);
        check("rst_tx_byte", {24'd0, tx_byte}, 32'd0);
        check("rst_dwrite", {24'd0, dwrite}, 32'd0);
        check("rst_raddr", {23'd0, raddr}, 32'd0);
        check("rst_waddr", {23'd0, waddr}, 32'd0);
        check("rst_startaddr", {23'd0, startaddr}, 32'd0);
    endtask

    initial begin
        rst        = 1'b0;
        received   = 1'b0;
        rx_byte    = 8'd0;
        cpu_halted = 1'b0;
        for (int i = 0; i < 512; i++) mem[i] = 8'd0;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // L 00 10 03 11 22 33
        exp_wr.push_back({9'h010, 8'h11});
        exp_wr.push_back({9'h011, 8'h22});
        exp_wr.push_back({9'h012, 8'h33});
        exp_tx.push_back(8'h66);
        send_byte(8'h4C); send_byte(8'h00); send_byte(8'h10); send_byte(8'h03);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        drain(200);

        // D 00 10 03
        exp_tx.push_back(8'h11);
        exp_tx.push_back(8'h22);
        exp_tx.push_back(8'h33);
        send_byte(8'h44); send_byte(8'h00); send_byte(8'h10); send_byte(8'h03);
        drain(300);

        // X 01 00, a byte during RUN is dropped, halt replies 'H'
        exp_go.push_back(9'h100);
        send_byte(8'h58); send_byte(8'h01); send_byte(8'h00);
        repeat (4) @(negedge clk);
        check("run_active", {31'd0, cpu_active}, 32'd1);
        send_byte(8'h5A);
        exp_tx.push_back(8'h48);
        @(negedge clk); cpu_halted = 1'b1;
        @(negedge clk); cpu_halted = 1'b0;
        @(negedge clk);
        check("halt_inactive", {31'd0, cpu_active}, 32'd0);
        drain(200);

        // X 00 05 with received and cpu_halted in the same cycle: only 'H'
        exp_go.push_back(9'h005);
        send_byte(8'h58); send_byte(8'h00); send_byte(8'h05);
        exp_tx.push_back(8'h48);
        @(negedge clk);
        rx_byte = 8'h4C; received = 1'b1; cpu_halted = 1'b1;
        @(negedge clk);
        received = 1'b0; cpu_halted = 1'b0;
        drain(200);
        repeat (20) @(negedge clk);

        // L 01 FF 02 AA BB wraps to address 0
        exp_wr.push_back({9'h1FF, 8'hAA});
        exp_wr.push_back({9'h000, 8'hBB});
        exp_tx.push_back(8'h65);
        send_byte(8'h4C); send_byte(8'h01); send_byte(8'hFF); send_byte(8'h02);
        send_byte(8'hAA); send_byte(8'hBB);
        drain(200);

        // L 00 00 then silence -> '!', then unknown 'Z' -> '?'
        exp_tx.push_back(8'h21);
        send_byte(8'h4C); send_byte(8'h00); send_byte(8'h00);
        repeat (150) @(negedge clk);
        drain(50);
        exp_tx.push_back(8'h3F);
        send_byte(8'h5A);
        drain(100);

        // reset in the middle of a 4-byte load after two data bytes
        exp_wr.push_back({9'h020, 8'h55});
        exp_wr.push_back({9'h021, 8'h66});
        send_byte(8'h4C); send_byte(8'h00); send_byte(8'h20); send_byte(8'h04);
        send_byte(8'h55); send_byte(8'h66);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs();
        rst = 1'b1;
        drain(20);
        repeat (150) @(negedge clk);
        exp_tx.push_back(8'h55);
        exp_tx.push_back(8'h66);
        send_byte(8'h44); send_byte(8'h00); send_byte(8'h20); send_byte(8'h02);
        drain(300);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, %0d tests run", tests);
        $fatal(1, "global timeout");
    end

endmodule
